dmem_readback_ctrl: RTL and testbench

//  Reader-side counterpart to the BRAM write-port loader. Sweeps a data BRAM through its

---
 rtl/dmem_readback_ctrl_pkg.sv | 5 +
 rtl/dmem_readback_ctrl_out_reg.sv | 32 +++
 rtl/dmem_readback_ctrl.sv | 88 ++++++++
 tb/tb_dmem_readback_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dmem_readback_ctrl_pkg.sv
// dmem_readback_ctrl_pkg: shared FSM encoding and constants for the BRAM readback controller
package dmem_readback_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND, S_CSUM, S_CSEND, S_DONE} state_t;
  localparam int ADDR_STEP = 4;
endpackage

// File: rtl/dmem_readback_ctrl_out_reg.sv
// dmem_readback_ctrl_out_reg: holding register for the outgoing beat, loaded and cleared by the FSM
module dmem_readback_ctrl_out_reg #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_last,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_addr  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= d_data;
      m_addr  <= d_addr;
      m_last  <= d_last;
    end else if (clr) begin
      m_valid <= 1'b0;
    end
endmodule

// File: rtl/dmem_readback_ctrl.sv
// dmem_readback_ctrl: sweeps a BRAM debug port and streams words on valid/ready.
// DMEM_READBACK_CHECKSUM_EN adds a trailing checksum beat and a checksum port.
module dmem_readback_ctrl
  import dmem_readback_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
`ifdef DMEM_READBACK_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0] remaining;
  logic hs, is_last, load;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] ld_addr;
  logic ld_last;
  assign hs = m_valid && m_ready;
  assign is_last = remaining == CNT_W'(1);
  assign debug_addr = addr;
  assign busy = state != S_IDLE && state != S_DONE;
  assign done = state == S_DONE;
  assign load = state == S_WAIT || state == S_CSUM;
`ifdef DMEM_READBACK_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
  assign ld_data = state == S_CSUM ? checksum : debug_data;
  assign ld_addr = state == S_CSUM ? '0 : addr;
  assign ld_last = state == S_CSUM;
  always_ff @(posedge clk or posedge rst)
    if (rst) checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (state == S_SEND && hs) checksum <= checksum + m_data;
`else
  localparam state_t S_AFTER = S_DONE;
  assign ld_data = debug_data;
  assign ld_addr = addr;
  assign ld_last = is_last;
`endif
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = word_count != '0 ? S_ISSUE : S_DONE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  state_n = S_SEND;
      S_SEND:  if (hs) state_n = is_last ? S_AFTER : S_ISSUE;
      S_CSUM:  state_n = S_CSEND;
      S_CSEND: if (hs) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        addr      <= {base_addr[ADDR_W-1:2], 2'b00};
        remaining <= word_count;
      end else if (state == S_SEND && hs) begin
        addr      <= addr + ADDR_W'(ADDR_STEP);
        remaining <= remaining - CNT_W'(1);
      end
    end
  dmem_readback_ctrl_out_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_out (
    .clk(clk), .rst(rst), .load(load), .clr(hs),
    .d_data(ld_data), .d_addr(ld_addr), .d_last(ld_last),
    .m_valid(m_valid), .m_data(m_data), .m_addr(m_addr), .m_last(m_last)
  );
endmodule

// File: tb/tb_dmem_readback_ctrl.sv
// tb_dmem_readback_ctrl: directed self-checking bench with a behavioural 1-cycle-latency BRAM
module tb_dmem_readback_ctrl;
`ifdef DMEM_READBACK_CHECKSUM_EN
  localparam bit CK = 1'b1;
  logic [31:0] checksum;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b0;
  logic [9:0] base_addr = '0, debug_addr, m_addr;
  logic [8:0] word_count = '0;
  logic [31:0] debug_data, m_data;
  logic m_valid, m_last, busy, done;
  logic [31:0] mem [256];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) debug_data <= mem[debug_addr[9:2]];
  dmem_readback_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .debug_addr(debug_addr), .debug_data(debug_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_addr(m_addr), .m_last(m_last),
`ifdef DMEM_READBACK_CHECKSUM_EN
    .checksum(checksum),
`endif
    .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_addr"}, 32'(m_addr), 0);
    check({tag, "_last"}, 32'(m_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_daddr"}, 32'(debug_addr), 0);
  endtask
  task automatic dump(input logic [9:0] base, input int cnt, input bit rnd, input bit poke);
    int k, cyc, first, done_cyc, hs_cyc, nb;
    bit pv, busy_seen;
    logic [31:0] pd, sum;
    logic [9:0] pa, ea;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = 9'(cnt);
    @(negedge clk);
    start = 1'b0;
    nb = cnt + ((cnt > 0 && CK) ? 1 : 0);
    k = 0; cyc = 1; first = -1; done_cyc = -1; hs_cyc = -1; pv = 0; busy_seen = 0; sum = '0;
    while (done_cyc < 0 && cyc < 300) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && cyc == 2;
      if (poke && cyc == 2) begin base_addr = 10'h100; word_count = 9'd5; end
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'(cnt > 0));
      busy_seen |= busy;
      if (pv) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_data", m_data, pd);
        check("hold_addr", 32'(m_addr), 32'(pa));
      end
      if (m_valid && first < 0) first = cyc;
      if (m_valid && m_ready) begin
        if (k < cnt) begin
          ea = (base & 10'h3fc) + 10'(4 * k);
          check("beat_addr", 32'(m_addr), 32'(ea));
          check("beat_data", m_data, 32'h1000_0000 + 32'(ea[9:2]));
          check("beat_last", 32'(m_last), 32'(!CK && k == cnt - 1));
          sum += 32'h1000_0000 + 32'(ea[9:2]);
        end else begin
          check("sum_addr", 32'(m_addr), 0);
          check("sum_data", m_data, sum);
          check("sum_last", 32'(m_last), 1);
        end
        k++;
        hs_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      pv = m_valid && !m_ready;
      pd = m_data;
      pa = m_addr;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("beats", 32'(k), 32'(nb));
    check("done_seen", 32'(done_cyc >= 0), 1);
    check("done_pulse_len", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
    if (cnt > 0) begin
      check("first_valid_lat", 32'(first), 3);
      check("done_lat", 32'(done_cyc), 32'(hs_cyc + 1));
    end else begin
      check("empty_done_lat", 32'(done_cyc), 1);
      check("empty_busy", 32'(busy_seen), 0);
      check("empty_valid", 32'(first), 32'(-1));
    end
`ifdef DMEM_READBACK_CHECKSUM_EN
    if (cnt > 0) check("checksum_port", checksum, sum);
`endif
  endtask
  initial begin
    bit done_seen;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");
    dump(10'h000, 4, 1'b0, 1'b0);
    dump(10'h000, 0, 1'b0, 1'b0);
    dump(10'h020, 3, 1'b1, 1'b1);
    dump(10'h3f8, 3, 1'b0, 1'b0);
    dump(10'h005, 2, 1'b1, 1'b0);
    @(negedge clk);
    m_ready = 1'b1; start = 1'b1; base_addr = 10'h000; word_count = 9'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_valid", 32'(m_valid), 1);
    check("pre_rst_addr", 32'(m_addr), 32'h004);
    #2 rst = 1'b1;
    #1 check_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      done_seen |= done;
    end
    check("no_done_after_rst", 32'(done_seen), 0);
    check("idle_after_rst", 32'(busy), 0);
    dump(10'h000, 8, 1'b0, 1'b0);
    dump(10'h3fc, 2, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
